program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 201 ++++++++++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Receives a DEPTH-byte program from a host over a valid/ready byte stream,
//   writes each byte into program RAM one cycle after it is accepted, and holds
//   the processor in reset until the whole program has arrived.  With the
//   checksum option enabled, one extra byte follows the program; the session
//   is accepted only when (sum of program bytes + checksum byte) mod 256 == 0.
//
//   Build option: define LOADER_CHECKSUM_EN to include the CHECK and FAIL
//   states and the running-sum logic.  Without it, the last program byte goes
//   straight to RUN and error is tied low.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     start      in   single-cycle request to begin a load session
//     in_valid   in   host offers in_data this cycle
//     in_data    in   program or checksum byte
//     in_ready   out  loader accepts a byte this cycle (registered)
//     ram_we     out  single-cycle RAM write strobe (registered)
//     ram_addr   out  RAM write address (registered, holds between writes)
//     ram_wdata  out  RAM write data (registered, holds between writes)
//     cpu_reset  out  processor held in reset while high (registered)
//     done       out  program accepted, processor released (registered)
//     error      out  checksum mismatch on the last session (registered)
//
//   DEPTH must equal 2**ADDR_W so the address counter wraps to 0 on the
//   last program byte.

module program_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAIL  = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic              in_ready_q, in_ready_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              xfer_s;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        sum_chk_s;
   logic              error_q, error_d;
`endif

   // in_ready is registered, so a transfer is judged against the registered copy
   assign xfer_s = in_valid & in_ready_q;

`ifdef LOADER_CHECKSUM_EN
   assign sum_chk_s = sum_q + in_data;
`endif

   // Next-state, address/sum update and write-strobe generation
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_RUN
`ifdef LOADER_CHECKSUM_EN
         , ST_FAIL
`endif
         : begin
            if (start) begin
               state_d = ST_LOAD;
               addr_d  = ADDR_ZERO;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = 8'h00;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (xfer_s) begin
               ram_we_d    = 1'b1;
               ram_addr_d  = addr_q;
               ram_wdata_d = in_data;
               addr_d      = addr_q + ADDR_ONE;   // wraps to 0 on the last byte
`ifdef LOADER_CHECKSUM_EN
               sum_d       = sum_chk_s;
               state_d     = (addr_q == ADDR_LAST) ? ST_CHECK : ST_LOAD;
`else
               state_d     = (addr_q == ADDR_LAST) ? ST_RUN : ST_LOAD;
`endif
            end else begin
               state_d = ST_LOAD;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (xfer_s) begin
               state_d = (sum_chk_s == 8'h00) ? ST_RUN : ST_FAIL;
            end else begin
               state_d = ST_CHECK;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they register glitch-free
   always_comb begin
      in_ready_d  = (state_d == ST_LOAD);
`ifdef LOADER_CHECKSUM_EN
      in_ready_d  = in_ready_d | (state_d == ST_CHECK);
      error_d     = (state_d == ST_FAIL);
`endif
      cpu_reset_d = (state_d != ST_RUN);
      done_d      = (state_d == ST_RUN);
   end

   // State and output registers; reset also cancels any pending RAM write
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= ADDR_ZERO;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= ADDR_ZERO;
         ram_wdata_q <= 8'h00;
         in_ready_q  <= 1'b0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= 8'h00;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         in_ready_q  <= in_ready_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
         error_q     <= error_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign error     = error_q;
`else
   assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader.  Follows the same LOADER_CHECKSUM_EN
//   build option as the design: checksum sessions are exercised when it is
//   defined, direct-to-RUN sessions otherwise.

module tb_program_loader;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int n_cmp = 0;
   int n_err = 0;

   // Write log filled by the monitor; indices wrap at 256 entries
   logic [ADDR_W-1:0] log_addr [0:255];
   logic [7:0]        log_data [0:255];
   int                wr_total = 0;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Record every RAM write, sampled away from the active edge
   always @(negedge clk) begin
      if (ram_we) begin
         log_addr[wr_total & 255] <= ram_addr;
         log_data[wr_total & 255] <= ram_wdata;
         wr_total                 <= wr_total + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle and confirm LOAD has been entered
   task automatic start_session(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_rdy"},  32'(in_ready),  32'd1);
      chk({tag, "_cpur"}, 32'(cpu_reset), 32'd1);
      chk({tag, "_done"}, 32'(done),      32'd0);
      chk({tag, "_err"},  32'(error),     32'd0);
   endtask

   // Sixteen back-to-back bytes first, first+inc, ...; each write checked after its edge
   task automatic load_session(input string tag, input logic [7:0] first, input logic [7:0] inc);
      logic [7:0] d;
      d = first;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = d;
         tick();
         chk({tag, "_we"},   32'(ram_we),    32'd1);
         chk({tag, "_addr"}, 32'(ram_addr),  32'(i));
         chk({tag, "_data"}, 32'(ram_wdata), 32'(d));
         d = d + inc;
      end
      in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk({tag, "_chk_rdy"},  32'(in_ready), 32'd1);
      chk({tag, "_chk_done"}, 32'(done),     32'd0);
`else
      chk({tag, "_run_done"}, 32'(done),      32'd1);
      chk({tag, "_run_cpur"}, 32'(cpu_reset), 32'd0);
      chk({tag, "_run_rdy"},  32'(in_ready),  32'd0);
      chk({tag, "_run_err"},  32'(error),     32'd0);
`endif
   endtask

`ifdef LOADER_CHECKSUM_EN
   // Offer the checksum byte and confirm the RUN/FAIL outcome
   task automatic send_cs(input string tag, input logic [7:0] cs, input logic ok);
      in_valid = 1'b1;
      in_data  = cs;
      tick();
      in_valid = 1'b0;
      chk({tag, "_cs_we"},   32'(ram_we),    32'd0);
      chk({tag, "_cs_done"}, 32'(done),      32'(ok));
      chk({tag, "_cs_err"},  32'(error),     32'(!ok));
      chk({tag, "_cs_cpur"}, 32'(cpu_reset), 32'(!ok));
      chk({tag, "_cs_rdy"},  32'(in_ready),  32'd0);
   endtask
`endif

   initial begin
      int base;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick();
      tick();

      // Reset state, checked while reset is still applied
      chk("rst_we",   32'(ram_we),    32'd0);
      chk("rst_rdy",  32'(in_ready),  32'd0);
      chk("rst_cpur", 32'(cpu_reset), 32'd1);
      chk("rst_done", 32'(done),      32'd0);
      chk("rst_err",  32'(error),     32'd0);
      reset = 1'b0;

      // Bytes offered in IDLE are ignored
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      tick();
      in_valid = 1'b0;
      chk("idle_rdy",  32'(in_ready),  32'd0);
      chk("idle_we",   32'(ram_we),    32'd0);
      chk("idle_cpur", 32'(cpu_reset), 32'd1);

      // Basic session 0x01..0x10; the sum is 0x88, so 0x78 balances it
      start_session("a");
      load_session("a", 8'h01, 8'h01);
`ifdef LOADER_CHECKSUM_EN
      send_cs("a", 8'h78, 1'b1);
`endif
      tick();
      chk("a_hold_done", 32'(done),      32'd1);
      chk("a_hold_cpur", 32'(cpu_reset), 32'd0);

      // Restart from RUN: processor goes back into reset the cycle after start
      start_session("rerun");
      load_session("rerun", 8'h00, 8'h00);
`ifdef LOADER_CHECKSUM_EN
      send_cs("rerun", 8'h00, 1'b1);

      // Wrong checksum lands in FAIL and stays there, ignoring offered bytes
      start_session("bad");
      load_session("bad", 8'h01, 8'h01);
      send_cs("bad", 8'h77, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      chk("fail_err",  32'(error),     32'd1);
      chk("fail_rdy",  32'(in_ready),  32'd0);
      chk("fail_we",   32'(ram_we),    32'd0);
      chk("fail_cpur", 32'(cpu_reset), 32'd1);
      chk("fail_done", 32'(done),      32'd0);
      start_session("recover");
      load_session("recover", 8'h01, 8'h01);
      send_cs("recover", 8'h78, 1'b1);
`else
      // All-0xFF program goes straight to RUN without a checksum byte
      start_session("ff");
      load_session("ff", 8'hFF, 8'h00);
      tick();
      chk("ff_err_hold", 32'(error), 32'd0);
`endif

      // Every-other-cycle valid with a start pulse mid-session
      start_session("gap");
      base = wr_total;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         in_valid = ((c % 2) == 0);
         in_data  = 8'(8'h10 + c / 2);
         start    = (c == 13);
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      tick();
      chk("gap_count", 32'(wr_total - base), 32'd16);
      for (int k = 0; k < DEPTH; k++) begin
         chk("gap_addr", 32'(log_addr[(base + k) & 255]), 32'(k));
         chk("gap_data", 32'(log_data[(base + k) & 255]), 32'(8'h10 + k));
      end
`ifdef LOADER_CHECKSUM_EN
      // Bytes 0x10..0x1F sum to 0x78 mod 256
      send_cs("gap", 8'h88, 1'b1);
`else
      chk("gap_done", 32'(done), 32'd1);
`endif

      // Reset after the 7th transfer aborts the session
      start_session("abort");
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h30 + i);
         tick();
      end
      chk("abort_we7", 32'(ram_we),   32'd1);
      chk("abort_a7",  32'(ram_addr), 32'd6);
      reset   = 1'b1;
      in_data = 8'hEE;
      tick();
      chk("abort_we",   32'(ram_we),    32'd0);
      chk("abort_rdy",  32'(in_ready),  32'd0);
      chk("abort_cpur", 32'(cpu_reset), 32'd1);
      chk("abort_done", 32'(done),      32'd0);
      reset = 1'b0;
      base  = wr_total;
      tick();
      tick();
      in_valid = 1'b0;
      chk("abort_nowr", 32'(wr_total - base), 32'd0);
      start_session("after");
      load_session("after", 8'h01, 8'h01);
`ifdef LOADER_CHECKSUM_EN
      send_cs("after", 8'h78, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
